// File: rtl/disp_pkg.sv
// Shared types and helpers for the result display scheduler.
package disp_pkg;

  localparam int MAX_SLOTS = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  // Returns {found, index} of the lowest set bit of v at or above position from.
  function automatic logic [IDX_W:0] find_valid(input logic [MAX_SLOTS-1:0] v,
                                                input logic [IDX_W:0]     from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (v[i] && ((IDX_W + 1)'(i) >= from)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/display_scheduler_tick_gen.sv
// Free-running modulo-DIV counter with synchronous clear and terminal-count pulse.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_clr,
  output logic o_tc
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr || (r_cnt == LAST)) r_cnt <= '0;
    else                          r_cnt <= r_cnt + CW'(1);
  end

  assign o_tc = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/display_scheduler.sv
// Steps through stored result slots for a 7-seg display, one value per dwell period.
// Optional inter-value blank gap enabled by defining DISP_BLANK_EN.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int SLOTS     = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int DWELL_DIV = 50000000,
  parameter int BLANK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [7:0] disp_val,
  output logic [2:0] disp_idx,
  output logic       disp_on,
  output logic       scan_tick,
  output logic       busy,
  output logic       done
);

  logic [MAX_SLOTS-1:0] r_valid;
  logic [7:0]           r_data [MAX_SLOTS];
  state_t               r_state, w_nxt_state, w_adv_state;
  idx_t                 r_idx, w_nxt_idx;
  logic                 r_empty_done, w_empty_start;
  logic                 w_wr_ok, w_dwell_tc, w_blank_tc;
  logic [MAX_SLOTS-1:0] w_wr_mask, w_valid;
  logic [IDX_W:0]       w_first, w_next;

  // A write landing in the same cycle as start or an advance is already visible.
  assign w_wr_ok   = wr_en && (32'(wr_addr) < SLOTS);
  assign w_wr_mask = w_wr_ok ? (MAX_SLOTS'(1) << wr_addr) : '0;
  assign w_valid   = r_valid | w_wr_mask;
  assign w_first   = find_valid(w_valid, '0);
  assign w_next    = find_valid(w_valid, (IDX_W + 1)'(r_idx) + (IDX_W + 1)'(1));

  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else     r_valid <= w_valid;
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_data[wr_addr] <= wr_data;
  end

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .i_clk (clk),
    .i_clr (rst),
    .o_tc  (scan_tick)
  );

  tick_gen #(.DIV(DWELL_DIV)) u_dwell (
    .i_clk (clk),
    .i_clr (rst || (r_state != SHOW)),
    .o_tc  (w_dwell_tc)
  );

  // Held in clear whenever BLANK is not entered, so it is inert without the gap.
  tick_gen #(.DIV(BLANK_DIV)) u_blank (
    .i_clk (clk),
    .i_clr (rst || (r_state != BLANK)),
    .o_tc  (w_blank_tc)
  );

`ifdef DISP_BLANK_EN
  assign w_adv_state = BLANK;
`else
  assign w_adv_state = SHOW;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_empty_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_idx        <= w_nxt_idx;
      r_empty_done <= w_empty_start;
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_idx     = r_idx;
    w_empty_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          if (w_first[IDX_W]) begin
            w_nxt_state = SHOW;
            w_nxt_idx   = w_first[IDX_W-1:0];
          end else begin
            w_empty_start = 1'b1;
          end
        end
      end
      SHOW: begin
        if (stop) begin
          w_nxt_state = IDLE;
        end else if (w_dwell_tc) begin
          if (w_next[IDX_W]) begin
            w_nxt_state = w_adv_state;
            w_nxt_idx   = w_next[IDX_W-1:0];
          end else if (loop) begin
            w_nxt_state = w_adv_state;
            w_nxt_idx   = w_first[IDX_W-1:0];
          end else begin
            w_nxt_state = DONE;
          end
        end
      end
      BLANK: begin
        if (stop)            w_nxt_state = IDLE;
        else if (w_blank_tc) w_nxt_state = SHOW;
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    disp_on  = 1'b0;
    disp_val = '0;
    done     = r_empty_done;
    case (r_state)
      SHOW: begin
        busy     = 1'b1;
        disp_on  = 1'b1;
        disp_val = r_data[r_idx];
      end
      BLANK: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign disp_idx = r_idx;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed and randomized checks of display_scheduler against a slot-list reference model.
module tb_display_scheduler;

  localparam int SLOTS = 6;
  localparam int SCAN  = 4;
  localparam int DWELL = 10;
  localparam int BLANK = 3;
`ifdef DISP_BLANK_EN
  localparam int GAP = BLANK;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] disp_val;
  logic [2:0] disp_idx;
  logic       disp_on, scan_tick, busy, done;

  int         total = 0;
  int         bad = 0;
  int         since_rst = 0;
  logic [7:0] m_val [8];
  bit   [7:0] m_valid = '0;

  display_scheduler #(
    .SLOTS     (SLOTS),
    .SCAN_DIV  (SCAN),
    .DWELL_DIV (DWELL),
    .BLANK_DIV (BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .disp_val  (disp_val),
    .disp_idx  (disp_idx),
    .disp_on   (disp_on),
    .scan_tick (scan_tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scan ticks land on every SCAN-th cycle counted from the last reset cycle.
  task automatic step();
    @(posedge clk);
    if (rst) since_rst = 0;
    else     since_rst++;
    #1;
    chk("scan_tick", 32'(scan_tick), 32'(!rst && ((since_rst % SCAN) == SCAN - 1)));
  endtask

  task automatic chk_out(input string tag, input bit on, input int idx, input int val,
                         input bit bsy, input bit dn);
    chk({tag, ".disp_on"}, 32'(disp_on), 32'(on));
    if (idx >= 0) chk({tag, ".disp_idx"}, 32'(disp_idx), 32'(idx));
    chk({tag, ".disp_val"}, 32'(disp_val), 32'(val));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    chk_out({tag, ".reset"}, 1'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    m_valid = '0;
  endtask

  task automatic write_slot(input int a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
    if (a < SLOTS) begin
      m_valid[a] = 1'b1;
      m_val[a] = d;
    end
    chk_out("write.idle", 1'b0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic begin_seq();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Walks the expected display order derived from the model's valid slots,
  // starting at the first SHOW cycle; a redundant start is issued at cycle 5.
  task automatic run_seq(input string tag, input bit lp, input int upd_slot, input int upd_c,
                         input logic [7:0] upd_v, input int stop_at);
    int order[$];
    int cyc = 0;
    int pass = 0;
    int k;
    bit fin = 1'b0;
    for (int i = 0; i < 8; i++) if (m_valid[i]) order.push_back(i);
    loop = lp;
    while (!fin && pass < 6) begin
      k = 0;
      while (!fin && k < order.size()) begin
        for (int c = 0; c < DWELL && !fin; c++) begin
          if (stop_at >= 0 && cyc == stop_at) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
            chk_out({tag, ".stop"}, 1'b0, -1, 0, 1'b0, 1'b0);
            step();
            chk_out({tag, ".after_stop"}, 1'b0, -1, 0, 1'b0, 1'b0);
            fin = 1'b1;
          end else begin
            chk_out({tag, ".show"}, 1'b1, order[k], int'(m_val[order[k]]), 1'b1, 1'b0);
            start = (cyc == 5);
            if (pass == 0 && order[k] == upd_slot && c == upd_c) begin
              wr_en = 1'b1;
              wr_addr = 3'(upd_slot);
              wr_data = upd_v;
            end
            step();
            start = 1'b0;
            if (wr_en) begin
              wr_en = 1'b0;
              m_val[upd_slot] = upd_v;
            end
            cyc++;
          end
        end
        if (!fin) begin
          if (k == order.size() - 1 && !lp) begin
            chk_out({tag, ".done"}, 1'b0, -1, 0, 1'b1, 1'b1);
            step();
            chk_out({tag, ".idle"}, 1'b0, -1, 0, 1'b0, 1'b0);
            fin = 1'b1;
          end else begin
            for (int b = 0; b < GAP; b++) begin
              chk_out({tag, ".blank"}, 1'b0, -1, 0, 1'b1, 1'b0);
              step();
              cyc++;
            end
          end
        end
        k++;
      end
      pass++;
    end
    chk({tag, ".finished"}, 32'(fin), 32'd1);
    loop = 1'b0;
  endtask

  task automatic empty_start(input string tag);
    begin_seq();
    chk_out({tag, ".done"}, 1'b0, -1, 0, 1'b0, 1'b1);
    step();
    chk_out({tag, ".after"}, 1'b0, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] v;
    int         mask;

    do_reset("basic");
    write_slot(0, 8'd7);
    write_slot(2, 8'd200);
    write_slot(5, 8'd99);
    write_slot(7, 8'd11);
    write_slot(6, 8'd12);
    begin_seq();
    run_seq("once", 1'b0, -1, 0, 8'd0, -1);

    do_reset("loop");
    write_slot(0, 8'd7);
    write_slot(2, 8'd200);
    write_slot(5, 8'd99);
    begin_seq();
    run_seq("loop", 1'b1, -1, 0, 8'd0, 35 + 3 * GAP);

    do_reset("empty");
    empty_start("empty");

    do_reset("upd");
    write_slot(0, 8'd7);
    write_slot(2, 8'd200);
    write_slot(5, 8'd99);
    begin_seq();
    run_seq("upd", 1'b0, 2, 3, 8'd55, -1);

    do_reset("midrst");
    write_slot(1, 8'd42);
    write_slot(3, 8'd43);
    begin_seq();
    for (int i = 0; i < 4; i++) begin
      chk_out("midrst.show", 1'b1, 1, 42, 1'b1, 1'b0);
      step();
    end
    do_reset("midrst");
    step();
    chk_out("midrst.idle", 1'b0, 0, 0, 1'b0, 1'b0);
    empty_start("midrst.empty");

    do_reset("samecyc");
    v = 8'($urandom);
    wr_en = 1'b1;
    wr_addr = 3'd4;
    wr_data = v;
    start = 1'b1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    m_valid[4] = 1'b1;
    m_val[4] = v;
    run_seq("samecyc", 1'b0, -1, 0, 8'd0, -1);

    for (int it = 0; it < 4; it++) begin
      do_reset("rand");
      mask = int'($urandom_range(1, 255));
      for (int a = 0; a < 8; a++) begin
        if (mask[a]) write_slot(a, 8'($urandom));
      end
      if (m_valid == '0) write_slot(int'($urandom_range(0, SLOTS - 1)), 8'($urandom));
      begin_seq();
      if (it == 3) run_seq("rand.loop", 1'b1, -1, 0, 8'd0, int'($urandom_range(20, 90)));
      else         run_seq("rand", 1'b0, int'($urandom_range(0, SLOTS - 1)),
                           int'($urandom_range(0, DWELL - 1)), 8'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
